// File: rtl/sha256_message_scheduler.sv
// rtl/sha256_message_scheduler.sv - SHA-256 message schedule generator streaming W[0..63] per 512-bit block
module sha256_message_scheduler (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] block_in,
  input  logic         block_valid,
  output logic         block_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   round_out,
  output logic         w_valid,
  input  logic         w_ready,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [31:0] win [16];
  logic [5:0]  round;
  logic        load, shift, last;
  logic [31:0] w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  always_comb begin
    state_n = state;
    load    = 1'b0;
    shift   = 1'b0;
    case (state)
      IDLE: begin
        if (block_valid) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (w_ready) begin
          shift = 1'b1;
          if (round == 6'd63) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign last   = shift && (round == 6'd63);
  assign w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      round <= '0;
      done  <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      state <= state_n;
      done  <= last;
      if (load) begin
        for (int i = 0; i < 16; i++) win[i] <= block_in[511-32*i -: 32];
        round <= '0;
      end else if (shift) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_next;
        round   <= last ? 6'd0 : round + 6'd1;
      end
    end
  end

  // Leftover window words past W[63] stay hidden while idle.
  assign block_ready = (state == IDLE);
  assign w_valid     = (state == RUN);
  assign w_out       = (state == RUN) ? win[0] : 32'd0;
  assign round_out   = round;

endmodule

// File: tb/tb_sha256_message_scheduler.sv
// tb/tb_sha256_message_scheduler.sv - scoreboard bench for sha256_message_scheduler
module tb_sha256_message_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic [31:0]  w_out;
  logic [5:0]   round_out;
  logic         w_valid;
  logic         w_ready;
  logic         done;

  sha256_message_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .block_in    (block_in),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .w_out       (w_out),
    .round_out   (round_out),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .done        (done)
  );

  always #5 clk = ~clk;

  logic [37:0] sb [$];
  logic [31:0] mw  [64];
  logic [31:0] cap [64];
  int          n_chk = 0;
  int          n_fail = 0;
  int          done_seen = 0;
  bit          exp_done = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_w;
  logic [5:0]  prev_r;

  localparam logic [511:0] ABC  = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] ZERO = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_block(input logic [511:0] b);
    for (int t = 0; t < 16; t++) mw[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      mw[t] = ss1(mw[t-2]) + mw[t-7] + ss0(mw[t-15]) + mw[t-16];
    for (int t = 0; t < 64; t++) sb.push_back({6'(t), mw[t]});
  endtask

  // Runs until the scoreboard is empty; returns in the done cycle.
  task automatic drain(input bit stall, output int cyc);
    cyc = 0;
    while (sb.size() != 0 && cyc < 2000) begin
      w_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain_complete", 64'(sb.size()), 64'd0);
    sb.delete();
    w_ready = 1'b1;
    chk("done_pulse", done, 1'b1);
    chk("block_ready_after", block_ready, 1'b1);
    chk("w_valid_after", w_valid, 1'b0);
  endtask

  task automatic send_block(input logic [511:0] b, input bit stall, output int cyc);
    chk("block_ready_before", block_ready, 1'b1);
    push_block(b);
    block_in    = b;
    block_valid = 1'b1;
    @(posedge clk); #1;
    block_valid = 1'b0;
    chk("w_valid_latency", w_valid, 1'b1);
    drain(stall, cyc);
  endtask

  task automatic check_abc_words();
    chk("abc_W0",  cap[0],  32'h61626380);
    chk("abc_W15", cap[15], 32'h00000018);
    chk("abc_W16", cap[16], 32'h61626380);
    chk("abc_W17", cap[17], 32'h000F0000);
  endtask

  // Monitor: pops on every transfer, checks stalls, done timing and idle output.
  always @(negedge clk) begin
    if (!reset) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done_timing", done, exp_done);
      exp_done = 1'b0;
      if (done) done_seen++;
      if (prev_stall) begin
        chk("stall_w_out", w_out, prev_w);
        chk("stall_round", round_out, prev_r);
      end
      if (!w_valid) chk("idle_w_out", w_out, 32'd0);
      if (w_valid && w_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", 64'(round_out), 64'hFFFF);
        end else begin
          logic [37:0] e;
          e = sb.pop_front();
          chk("round_out", round_out, e[37:32]);
          chk("w_out", w_out, e[31:0]);
          cap[round_out] = w_out;
          if (round_out == 6'd63) exp_done = 1'b1;
        end
      end
      prev_stall = w_valid && !w_ready;
      prev_w     = w_out;
      prev_r     = round_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int d0;
    logic [511:0] rb;

    reset       = 1'b0;
    block_valid = 1'b0;
    block_in    = '0;
    w_ready     = 1'b0;
    #12;
    chk("rst_block_ready", block_ready, 1'b1);
    chk("rst_w_valid", w_valid, 1'b0);
    chk("rst_w_out", w_out, 32'd0);
    chk("rst_round_out", round_out, 6'd0);
    chk("rst_done", done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    // "abc" block accepted on the first edge after reset release, no stalls
    send_block(ABC, 1'b0, cyc);
    chk("abc_transfer_cycles", 64'(cyc), 64'd64);
    check_abc_words();
    @(posedge clk); #1;
    chk("abc_done_count", 64'(done_seen), 64'd1);
    chk("done_single_cycle", done, 1'b0);

    // all-zero block
    send_block(ZERO, 1'b0, cyc);
    chk("zero_W63", cap[63], 32'd0);
    @(posedge clk); #1;
    chk("zero_done_count", 64'(done_seen), 64'd2);

    // "abc" under random back-pressure
    for (int i = 0; i < 64; i++) cap[i] = 32'hDEADBEEF;
    send_block(ABC, 1'b1, cyc);
    check_abc_words();
    @(posedge clk); #1;

    // reset at round 30
    d0 = done_seen;
    push_block(ABC);
    block_in    = ABC;
    block_valid = 1'b1;
    @(posedge clk); #1;
    block_valid = 1'b0;
    w_ready     = 1'b1;
    cyc = 0;
    while (round_out != 6'd30 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached_round30", round_out, 6'd30);
    reset = 1'b0;
    #1;
    chk("midrst_w_valid", w_valid, 1'b0);
    chk("midrst_w_out", w_out, 32'd0);
    chk("midrst_round_out", round_out, 6'd0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_block_ready", block_ready, 1'b1);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    send_block(ZERO, 1'b0, cyc);
    @(posedge clk); #1;
    chk("midrst_done_count", 64'(done_seen - d0), 64'd1);

    // block_valid held through RUN, second block taken in the done cycle
    for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
    push_block(ABC);
    block_in    = ABC;
    block_valid = 1'b1;
    @(posedge clk); #1;
    block_in = rb;
    drain(1'b0, cyc);
    check_abc_words();
    push_block(rb);
    @(posedge clk); #1;
    block_valid = 1'b0;
    chk("b2b_w_valid", w_valid, 1'b1);
    chk("b2b_round0", round_out, 6'd0);
    chk("b2b_W0", w_out, rb[511:480]);
    drain(1'b0, cyc);
    @(posedge clk); #1;

    // random blocks with random stalls
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
      send_block(rb, 1'b1, cyc);
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_message_scheduler.md
SHA256_MESSAGE_SCHEDULER -- requirements
Module: sha256_message_scheduler

Interface
REQ-001 The module SHALL have no parameters; the round count is fixed at 64 and the word width at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 block_in  input  512  message block; bits [511:480] = M0 ... bits [31:0] = M15.
REQ-005 block_valid  input  1  block_in is valid this cycle.
REQ-006 block_ready  output  1  scheduler can accept a new block.
REQ-007 w_out  output  32  current schedule word W[t], feeding the compression round's w_in.
REQ-008 round_out  output  6  index t of w_out, 0..63.
REQ-009 w_valid  output  1  w_out and round_out are valid.
REQ-010 w_ready  input  1  consumer accepts w_out this cycle.
REQ-011 done  output  1  one-cycle pulse after W[63] is accepted.

Function
REQ-012 The module SHALL hold a 16-word window register win[0..15], where win[0] = W[t] and win[15] = W[t+15].
REQ-013 The module SHALL implement exactly two states, IDLE and RUN.
- IDLE: block_ready=1, w_valid=0.
- RUN: block_ready=0, w_valid=1.
REQ-014 In IDLE, block_valid=1 SHALL load win[i] = M_i, clear round to 0 and enter RUN on the next edge; w_valid SHALL rise the cycle after the accept, giving one cycle of latency.
REQ-015 In RUN, w_out SHALL equal win[0] and round_out SHALL equal the round counter, both driven directly from registers.
REQ-016 A transfer occurs on a rising edge with w_valid=1 and w_ready=1. On each transfer the window SHALL shift: win[i] <= win[i+1] for i = 0..14.
REQ-017 On each transfer, win[15] SHALL be loaded with s1(win[14]) + win[9] + s0(win[1]) + win[0], computed modulo 2^32 with carries discarded; this value is W[t+16].
REQ-018 The small sigma functions SHALL be defined as:
- s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
- s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
ROTR is a 32-bit rotate right; SHR is a logical shift right.
REQ-019 When w_valid=1 and w_ready=0, w_out, round_out, win and round SHALL hold unchanged; back-pressure may last any number of cycles.
REQ-020 On each transfer with round < 63, round SHALL increment by 1.
REQ-021 On the transfer with round = 63, the module SHALL:
- return to IDLE;
- clear round to 0;
- drive done=1 for exactly the next cycle.
REQ-022 Window words computed beyond W[63] are don't-care and SHALL NOT be visible on w_out.
REQ-023 block_valid SHALL be ignored in RUN; a block presented then is not consumed.
REQ-024 In the cycle done=1, the module SHALL already be in IDLE, so a back-to-back block_valid accept is legal in that cycle.
REQ-025 Outputs SHALL NOT depend combinationally on any input.

Reset
REQ-026 While reset=0, the module SHALL hold these values asynchronously:
- state = IDLE, round = 0, every win word = 0;
- w_out = 0, round_out = 0, w_valid = 0, done = 0;
- block_ready = 1.
REQ-027 Reset asserted mid-RUN SHALL abandon the block immediately with no done pulse. After release, the next block starts at round 0.
REQ-028 The first accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-029 "abc" padded block (M0=0x61626380, M1..M14=0, M15=0x00000018), w_ready=1 held -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000; 64 consecutive transfers, then done pulse, then block_ready=1.
REQ-030 All-zero block -> W0..W63 all 0x00000000; round_out steps 0..63; exactly one done pulse.
REQ-031 Random w_ready stall pattern on the "abc" block -> W sequence identical to REQ-029; w_out and round_out stable during every stall cycle.
REQ-032 Reset=0 asserted at round 30, then released, then all-zero block loaded -> outputs cleared immediately; no done pulse; new sequence starts at round_out=0.
REQ-033 block_valid held high during RUN, second block presented in the done cycle -> mid-run block ignored; second block accepted in the done cycle; W0 of the second block appears on the next cycle.
REQ-034 Scoreboard for random blocks: compare all 64 words against a reference model of REQ-017/REQ-018 -> all match.
